mc_control_unit: RTL and testbench

//  Multi-cycle control FSM driving the ALU and datapath of the multi-cycle RV32I core. Sequences
//  IF/ID/EX/MEM/WB per instruction, issues alu_op and the ALU operand selects, and consumes alu_bcond
//  to resolve branches. Drives the mux selects and write enables for PC, IR, register file and memory.

---
 rtl/mc_control_unit_pkg.sv | 74 +++++++
 rtl/mc_control_unit_alu_ctrl_decode.sv | 48 ++++
 rtl/mc_control_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM state
// encodings, opcode constants, ALU operation encodings, datapath mux select
// constants and the packed bundle of control outputs.
package mc_control_unit_pkg;

    // Control FSM states, one per instruction phase plus the absorbing HALT.
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    // RV32I major opcodes handled by the sequencer.
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [31:0] INSN_ECALL = 32'h0000_0073;

    // ALU operation encodings. ALU_ZERO yields 0 / never-taken for branches.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_ZERO = 4'd7;
    localparam logic [3:0] ALU_BEQ  = 4'd8;
    localparam logic [3:0] ALU_BNE  = 4'd9;
    localparam logic [3:0] ALU_BLT  = 4'd10;
    localparam logic [3:0] ALU_BGE  = 4'd11;

    // Datapath mux selects.
    localparam logic [1:0] ALU_SRC_A_PC     = 2'd0;
    localparam logic [1:0] ALU_SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] ALU_SRC_A_RS1    = 2'd2;
    localparam logic [1:0] ALU_SRC_B_RS2    = 2'd0;
    localparam logic [1:0] ALU_SRC_B_IMM    = 2'd1;
    localparam logic [1:0] ALU_SRC_B_FOUR   = 2'd2;
    localparam logic       PC_SRC_ALU       = 1'b0;
    localparam logic       PC_SRC_ALUOUT    = 1'b1;
    localparam logic [1:0] WB_SEL_ALUOUT    = 2'd0;
    localparam logic [1:0] WB_SEL_MDR       = 2'd1;
    localparam logic [1:0] WB_SEL_PC        = 2'd2;

    // All control outputs except alu_op, so they can be cleared as one unit.
    typedef struct packed {
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retire;
        logic       halted;
    } ctrl_t;

    function automatic logic is_load(input logic [6:0] opcode);
        return (opcode == OP_LOAD);
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_ctrl_decode.sv
// ALU control decode: maps (opcode, funct3, ir[30]) to an ALU operation.
//   opcode    in  7  instruction major opcode
//   funct3    in  3  instruction funct3 field
//   funct7_b5 in  1  ir[30], selects SUB for R-type funct3=000
//   alu_op    out ALU_OP_W  ALU operation
module mc_control_unit_alu_ctrl_decode
    import mc_control_unit_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_b5,
    output logic [ALU_OP_W-1:0] alu_op
);

    // Branch compares use their own op set; everything else is arithmetic.
    always_comb begin
        alu_op = ALU_OP_W'(ALU_ZERO);
        if (opcode == OP_BRANCH) begin
            case (funct3)
                3'b000:  alu_op = ALU_OP_W'(ALU_BEQ);
                3'b001:  alu_op = ALU_OP_W'(ALU_BNE);
                3'b100:  alu_op = ALU_OP_W'(ALU_BLT);
                3'b101:  alu_op = ALU_OP_W'(ALU_BGE);
                default: alu_op = ALU_OP_W'(ALU_ZERO);
            endcase
        end else begin
            case (funct3)
                3'b000: begin
                    // ir[30] only means SUB for register-register ops; ADDI ignores it.
                    if ((opcode == OP_R) && funct7_b5) begin
                        alu_op = ALU_OP_W'(ALU_SUB);
                    end else begin
                        alu_op = ALU_OP_W'(ALU_ADD);
                    end
                end
                3'b001:  alu_op = ALU_OP_W'(ALU_SLL);
                3'b100:  alu_op = ALU_OP_W'(ALU_XOR);
                3'b101:  alu_op = ALU_OP_W'(ALU_SRL);
                3'b110:  alu_op = ALU_OP_W'(ALU_OR);
                3'b111:  alu_op = ALU_OP_W'(ALU_AND);
                default: alu_op = ALU_OP_W'(ALU_ZERO);
            endcase
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM. Sequences IF/ID/EX/MEM/WB, drives the ALU
// op and operand selects, PC/IR/regfile/memory enables, and stalls on
// mem_ready. Outputs are combinational from state, ir, alu_bcond, mem_ready
// and are all held at 0 while reset_n is low.
//   clk, reset_n            clock, async active-low reset
//   ir, alu_bcond, mem_ready instruction, branch result, memory handshake
//   alu_op, alu_src_a/b     ALU control
//   pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write, wb_sel
//                           datapath control
//   retire, halted          last-cycle pulse, sticky halt flag
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int ALU_OP_W      = 4,
    parameter bit HALT_ON_ECALL = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [31:0]         ir,
    input  logic                alu_bcond,
    input  logic                mem_ready,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                pc_write,
    output logic                pc_src,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic                retire,
    output logic                halted
);

    state_t                state_r;
    state_t                state_next_s;
    logic [6:0]            opcode_s;
    logic [ALU_OP_W-1:0]   decode_op_s;
    logic [ALU_OP_W-1:0]   alu_op_s;
    ctrl_t                 ctrl_s;
    ctrl_t                 ctrl_gated_s;

    assign opcode_s = ir[6:0];

    mc_control_unit_alu_ctrl_decode #(
        .ALU_OP_W (ALU_OP_W)
    ) u_alu_ctrl_decode (
        .opcode    (opcode_s),
        .funct3    (ir[14:12]),
        .funct7_b5 (ir[30]),
        .alu_op    (decode_op_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IF;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control output decode.
    always_comb begin
        state_next_s = state_r;
        alu_op_s     = ALU_OP_W'(ALU_ADD);
        ctrl_s       = '0;
        case (state_r)
            S_IF: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.i_or_d    = 1'b0;
                ctrl_s.alu_src_a = ALU_SRC_A_PC;
                ctrl_s.alu_src_b = ALU_SRC_B_FOUR;
                ctrl_s.pc_src    = PC_SRC_ALU;
                if (mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                    state_next_s    = S_ID;
                end else begin
                    state_next_s    = S_IF;
                end
            end
            S_ID: begin
                // OLD_PC+IMM lands in ALUOut as the branch/JAL target.
                ctrl_s.alu_src_a = ALU_SRC_A_OLD_PC;
                ctrl_s.alu_src_b = ALU_SRC_B_IMM;
                if (ir == INSN_ECALL) begin
                    if (HALT_ON_ECALL) begin
                        state_next_s  = S_HALT;
                    end else begin
                        ctrl_s.retire = 1'b1;
                        state_next_s  = S_IF;
                    end
                end else begin
                    state_next_s = S_EX;
                end
            end
            S_EX: begin
                case (opcode_s)
                    OP_R: begin
                        alu_op_s         = decode_op_s;
                        ctrl_s.alu_src_a = ALU_SRC_A_RS1;
                        ctrl_s.alu_src_b = ALU_SRC_B_RS2;
                        state_next_s     = S_WB;
                    end
                    OP_I: begin
                        alu_op_s         = decode_op_s;
                        ctrl_s.alu_src_a = ALU_SRC_A_RS1;
                        ctrl_s.alu_src_b = ALU_SRC_B_IMM;
                        state_next_s     = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctrl_s.alu_src_a = ALU_SRC_A_RS1;
                        ctrl_s.alu_src_b = ALU_SRC_B_IMM;
                        state_next_s     = S_MEM;
                    end
                    OP_BRANCH: begin
                        // Target already in ALUOut; the ALU is free for the compare.
                        alu_op_s         = decode_op_s;
                        ctrl_s.alu_src_a = ALU_SRC_A_RS1;
                        ctrl_s.alu_src_b = ALU_SRC_B_RS2;
                        ctrl_s.pc_write  = alu_bcond;
                        ctrl_s.pc_src    = PC_SRC_ALUOUT;
                        ctrl_s.retire    = 1'b1;
                        state_next_s     = S_IF;
                    end
                    OP_JAL: begin
                        // PC already holds PC+4, which is the link value.
                        ctrl_s.pc_write  = 1'b1;
                        ctrl_s.pc_src    = PC_SRC_ALUOUT;
                        ctrl_s.reg_write = 1'b1;
                        ctrl_s.wb_sel    = WB_SEL_PC;
                        ctrl_s.retire    = 1'b1;
                        state_next_s     = S_IF;
                    end
                    OP_JALR: begin
                        ctrl_s.alu_src_a = ALU_SRC_A_RS1;
                        ctrl_s.alu_src_b = ALU_SRC_B_IMM;
                        ctrl_s.pc_write  = 1'b1;
                        ctrl_s.pc_src    = PC_SRC_ALU;
                        ctrl_s.reg_write = 1'b1;
                        ctrl_s.wb_sel    = WB_SEL_PC;
                        ctrl_s.retire    = 1'b1;
                        state_next_s     = S_IF;
                    end
                    default: begin
                        // Unknown opcode retires as a NOP; PC advanced in IF.
                        ctrl_s.retire = 1'b1;
                        state_next_s  = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                ctrl_s.i_or_d    = 1'b1;
                ctrl_s.mem_read  = is_load(opcode_s);
                ctrl_s.mem_write = !is_load(opcode_s);
                if (mem_ready) begin
                    if (is_load(opcode_s)) begin
                        state_next_s  = S_WB;
                    end else begin
                        ctrl_s.retire = 1'b1;
                        state_next_s  = S_IF;
                    end
                end else begin
                    state_next_s = S_MEM;
                end
            end
            S_WB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.wb_sel    = is_load(opcode_s) ? WB_SEL_MDR : WB_SEL_ALUOUT;
                ctrl_s.retire    = 1'b1;
                state_next_s     = S_IF;
            end
            S_HALT: begin
                ctrl_s.halted = 1'b1;
                state_next_s  = S_HALT;
            end
            default: begin
                state_next_s = S_IF;
            end
        endcase
    end

    // Reset gating makes every output 0 the moment reset_n falls.
    assign ctrl_gated_s = reset_n ? ctrl_s : '0;
    assign alu_op       = reset_n ? alu_op_s : '0;
    assign alu_src_a    = ctrl_gated_s.alu_src_a;
    assign alu_src_b    = ctrl_gated_s.alu_src_b;
    assign pc_write     = ctrl_gated_s.pc_write;
    assign pc_src       = ctrl_gated_s.pc_src;
    assign ir_write     = ctrl_gated_s.ir_write;
    assign i_or_d       = ctrl_gated_s.i_or_d;
    assign mem_read     = ctrl_gated_s.mem_read;
    assign mem_write    = ctrl_gated_s.mem_write;
    assign reg_write    = ctrl_gated_s.reg_write;
    assign wb_sel       = ctrl_gated_s.wb_sel;
    assign retire       = ctrl_gated_s.retire;
    assign halted       = ctrl_gated_s.halted;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed scoreboard bench for mc_control_unit: each cycle the expected
// output vector is queued when inputs are driven, then popped and compared
// on the falling clock edge.
module tb_mc_control_unit;
    import mc_control_unit_pkg::*;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] a;
        logic [1:0] b;
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retire;
        logic       halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ir;
    logic        alu_bcond;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_a, alu_src_b, wb_sel;
    logic        pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, retire, halted;
    vec_t        act;

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    mc_control_unit #(.ALU_OP_W(4), .HALT_ON_ECALL(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .ir(ir), .alu_bcond(alu_bcond),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .wb_sel(wb_sel),
        .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    assign act = {alu_op, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
                  i_or_d, mem_read, mem_write, reg_write, wb_sel, retire, halted};

    function automatic vec_t v_zero();
        return '0;
    endfunction

    function automatic vec_t v_if(input logic rdy);
        vec_t v = '0;
        v.alu_op = ALU_ADD; v.a = 2'd0; v.b = 2'd2; v.mem_read = 1'b1;
        v.ir_write = rdy; v.pc_write = rdy;
        return v;
    endfunction

    function automatic vec_t v_id();
        vec_t v = '0;
        v.alu_op = ALU_ADD; v.a = 2'd1; v.b = 2'd1;
        return v;
    endfunction

    function automatic vec_t v_ex(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                                  input logic pcw, input logic pcs, input logic rw,
                                  input logic [1:0] wb, input logic ret);
        vec_t v = '0;
        v.alu_op = op; v.a = a; v.b = b; v.pc_write = pcw; v.pc_src = pcs;
        v.reg_write = rw; v.wb_sel = wb; v.retire = ret;
        return v;
    endfunction

    function automatic vec_t v_mem(input logic load, input logic rdy);
        vec_t v = '0;
        v.i_or_d = 1'b1; v.mem_read = load; v.mem_write = ~load;
        v.retire = rdy & ~load;
        return v;
    endfunction

    function automatic vec_t v_wb(input logic load);
        vec_t v = '0;
        v.reg_write = 1'b1; v.wb_sel = load ? 2'd1 : 2'd0; v.retire = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_halt();
        vec_t v = '0;
        v.halted = 1'b1;
        return v;
    endfunction

    // Queue the expectation for this cycle, compare at negedge, advance past posedge.
    task automatic cyc(input string tag, input vec_t e);
        vec_t  ev;
        string tg;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        ev = exp_q.pop_front();
        tg = tag_q.pop_front();
        checks++;
        assert (act === ev) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tg, act, ev);
        end
        @(posedge clk);
        #1;
    endtask

    // Fetch/decode prologue with mem_ready=1.
    task automatic fetch(input string tag, input logic [31:0] insn);
        ir = insn; mem_ready = 1'b1; alu_bcond = 1'b0;
        cyc({tag, "_if"}, v_if(1'b1));
        cyc({tag, "_id"}, v_id());
    endtask

    initial begin
        reset_n = 1'b0; ir = 32'h0; alu_bcond = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_zero", v_zero());
        reset_n = 1'b1;

        // add: IF ID EX WB, then next IF at cycle 5
        fetch("add", 32'h002081B3);
        cyc("add_ex", v_ex(ALU_ADD, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("add_wb", v_wb(1'b0));

        fetch("sub", 32'h40208133);
        cyc("sub_ex", v_ex(ALU_SUB, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("sub_wb", v_wb(1'b0));

        fetch("addi", 32'h00508093);
        cyc("addi_ex", v_ex(ALU_ADD, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("addi_wb", v_wb(1'b0));

        // xori funct3=100 and an unsupported funct3=010 (slti)
        fetch("xori", 32'h0050C093);
        cyc("xori_ex", v_ex(ALU_XOR, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("xori_wb", v_wb(1'b0));
        fetch("slti", 32'h0050A093);
        cyc("slti_ex", v_ex(ALU_ZERO, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("slti_wb", v_wb(1'b0));

        // beq taken / not taken
        fetch("beq_t", 32'h00208463);
        alu_bcond = 1'b1;
        cyc("beq_t_ex", v_ex(ALU_BEQ, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
        fetch("beq_n", 32'h00208463);
        alu_bcond = 1'b0;
        cyc("beq_n_ex", v_ex(ALU_BEQ, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1));
        fetch("bne", 32'h00209463);
        alu_bcond = 1'b1;
        cyc("bne_ex", v_ex(ALU_BNE, 2'd2, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1));
        fetch("bge", 32'h0020D463);
        alu_bcond = 1'b0;
        cyc("bge_ex", v_ex(ALU_BGE, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1));
        fetch("b010", 32'h0020A463);
        cyc("b010_ex", v_ex(ALU_ZERO, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1));

        // lw with 3 stalled MEM cycles: WB lands on cycle 8
        fetch("lw", 32'h0000A183);
        cyc("lw_ex", v_ex(ALU_ADD, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", v_mem(1'b1, 1'b0));
        mem_ready = 1'b1;
        cyc("lw_mem_done", v_mem(1'b1, 1'b1));
        cyc("lw_wb", v_wb(1'b1));

        // sw completing normally: 4 cycles, retire in MEM
        fetch("sw", 32'h0020A023);
        cyc("sw_ex", v_ex(ALU_ADD, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("sw_mem", v_mem(1'b0, 1'b1));

        // jal / jalr / unknown opcode
        fetch("jal", 32'h008000EF);
        cyc("jal_ex", v_ex(ALU_ADD, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1));
        fetch("jalr", 32'h000080E7);
        cyc("jalr_ex", v_ex(ALU_ADD, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1));
        fetch("fence", 32'h0000000F);
        cyc("fence_ex", v_ex(ALU_ADD, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));

        // IF stall for 2 cycles, then sw reset mid-MEM
        ir = 32'h0020A023; mem_ready = 1'b0;
        cyc("if_wait0", v_if(1'b0));
        cyc("if_wait1", v_if(1'b0));
        mem_ready = 1'b1;
        cyc("if_go", v_if(1'b1));
        cyc("sw2_id", v_id());
        cyc("sw2_ex", v_ex(ALU_ADD, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        mem_ready = 1'b0;
        cyc("sw2_mem_wait", v_mem(1'b0, 1'b0));
        reset_n = 1'b0;
        cyc("sw2_reset", v_zero());
        reset_n = 1'b1;
        cyc("post_reset_if", v_if(1'b0));
        mem_ready = 1'b1;
        cyc("post_reset_if_go", v_if(1'b1));
        cyc("post_reset_id", v_id());
        cyc("post_reset_ex", v_ex(ALU_ADD, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        cyc("post_reset_mem", v_mem(1'b0, 1'b1));

        // ecall halts; sticky regardless of ir/mem_ready
        fetch("ecall", 32'h00000073);
        for (int i = 0; i < 12; i++) begin
            ir = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            alu_bcond = 1'($urandom_range(0, 1));
            cyc("halt", v_halt());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
